// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Two-state instruction fetch unit. Requests a word at pc,
//               holds it for decode until accepted, then advances pc to the
//               sequential, branch or jump target.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               memAddress/memRequest - instruction memory request (addr = pc)
//               memReady/memData      - memory response
//               instruction/instructionValid/instructionAccept - decode handshake
//               jumpEnable/jumpTarget - jump redirect (sampled on accept)
//               branchEnable/isZero/branchOffset - conditional branch (on accept)
//               pc, fetchCount        - current pc, accepted-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] memAddress,
    output logic        memRequest,
    input  logic        memReady,
    input  logic [31:0] memData,
    output logic [31:0] instruction,
    output logic        instructionValid,
    input  logic        instructionAccept,
    input  logic        jumpEnable,
    input  logic [25:0] jumpTarget,
    input  logic        branchEnable,
    input  logic        isZero,
    input  logic [31:0] branchOffset,
    output logic [31:0] pc,
    output logic [31:0] fetchCount
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // Target selection; all sums wrap modulo 2^32 by width truncation.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        next_pc  = pc_plus4;
        if (jumpEnable) begin
            next_pc = {pc_plus4[31:28], jumpTarget, 2'b00};
        end else if (branchEnable && isZero) begin
            next_pc = pc_plus4 + {branchOffset[29:0], 2'b00};
        end
    end

    // Next-state: memory response only matters in FETCH, decode handshake
    // and redirect controls only matter in HOLD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            FETCH: begin
                if (memReady) begin
                    instr_d = memData;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instructionAccept) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset takes precedence, so a memReady coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign memRequest       = (state_q == FETCH);
    assign instructionValid = (state_q == HOLD);
    assign memAddress       = pc_q;
    assign pc               = pc_q;
    assign instruction      = instr_q;
    assign fetchCount       = count_q;

endmodule
`default_nettype wire
